// File: rtl/phoenix_rom_loader.sv
// HPS ROM stream to Phoenix ROM/PROM write strobes, plus core reset sequencing.
// Optional checksum check enabled by defining PHOENIX_ROM_CKSUM_EN.
module phoenix_rom_loader #(
  parameter int          PROG_SIZE    = 16384,
  parameter int          BG_SIZE      = 4096,
  parameter int          FG_SIZE      = 4096,
  parameter int          PROM_SIZE    = 512,
  parameter int          HOLD_CYCLES  = 64,
  parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        prog_we,
  output logic        bg_we,
  output logic        fg_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  localparam logic [25:0] BG_BASE =
    26'(PROG_SIZE);
  localparam logic [25:0] FG_BASE =
    26'(PROG_SIZE + BG_SIZE);
  localparam logic [25:0] PROM_BASE =
    26'(PROG_SIZE + BG_SIZE + FG_SIZE);
  localparam logic [25:0] TOTAL =
    26'(PROG_SIZE + BG_SIZE + FG_SIZE + PROM_SIZE);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);

  state_t        state, state_nx;
  logic          dl_q;
  logic [25:0]   cnt, cnt_nx, cnt_base;
  logic          err, err_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [3:0]    we_q, we_nx;
  logic [13:0]   addr_nx;
  logic [25:0]   addr_x, base;
  logic          start, accept, in_range;
  logic          r_prog, r_bg, r_fg, r_prom;
  logic          load_end, sum_bad;

  assign addr_x = {1'b0, ioctl_addr};

  // Only a fresh rising edge starts a download, so a stream cut by reset stays ignored.
  assign start = ioctl_download & ~dl_q &
                 (ioctl_index == 8'h00) &
                 ((state == IDLE) | (state == RUN));

  // In LOAD the final byte is taken even when download drops in that cycle.
  assign accept = ioctl_wr &
                  (ioctl_index == 8'h00) &
                  ((state == LOAD) | start);

  assign load_end = (state == LOAD) & ~ioctl_download;

  assign r_prog   = addr_x < BG_BASE;
  assign r_bg     = ~r_prog & (addr_x < FG_BASE);
  assign r_fg     = ~r_prog & ~r_bg &
                    (addr_x < PROM_BASE);
  assign in_range = addr_x < TOTAL;
  assign r_prom   = ~r_prog & ~r_bg & ~r_fg &
                    in_range;

  always_comb begin
    we_nx = 4'b0000;
    base  = '0;
    unique case (1'b1)
      r_prog: we_nx = 4'b0001;
      r_bg: begin
        we_nx = 4'b0010;
        base  = BG_BASE;
      end
      r_fg: begin
        we_nx = 4'b0100;
        base  = FG_BASE;
      end
      r_prom: begin
        we_nx = 4'b1000;
        base  = PROM_BASE;
      end
      default: we_nx = 4'b0000;
    endcase
    if (!accept) we_nx = 4'b0000;
    addr_nx = 14'(addr_x - base);
  end

`ifdef PHOENIX_ROM_CKSUM_EN
  logic [15:0] sum, sum_nx;

  always_comb begin
    sum_nx = start ? 16'h0000 : sum;
    if (accept && in_range)
      sum_nx = sum_nx + {8'h00, ioctl_dout};
  end

  assign sum_bad = sum_nx != EXPECTED_SUM;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum <= 16'h0000;
    else          sum <= sum_nx;
  end
`else
  logic [15:0] unused_sum;
  assign unused_sum = EXPECTED_SUM;
  assign sum_bad    = 1'b0;
`endif

  always_comb begin
    cnt_base = start ? '0 : cnt;
    cnt_nx   = cnt_base;
    if (accept && (addr_x + 26'd1 > cnt_base))
      cnt_nx = addr_x + 26'd1;
    err_nx = (err & ~start) | (accept & ~in_range);
    if (load_end && ((cnt_nx < TOTAL) || sum_bad))
      err_nx = 1'b1;
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (!ioctl_download) begin
          state_nx = HOLD;
          hold_nx  = '0;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = RUN;
        else hold_nx = hold_cnt + HW'(1);
      end
      RUN: if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dl_q     <= 1'b1;
      cnt      <= '0;
      err      <= 1'b0;
      hold_cnt <= '0;
      we_q     <= 4'b0000;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      state    <= state_nx;
      dl_q     <= ioctl_download;
      cnt      <= cnt_nx;
      err      <= err_nx;
      hold_cnt <= hold_nx;
      we_q     <= we_nx;
      if (accept) begin
        rom_addr <= addr_nx;
        rom_data <= ioctl_dout;
      end
    end
  end

  assign prog_we    = we_q[0];
  assign bg_we      = we_q[1];
  assign fg_we      = we_q[2];
  assign prom_we    = we_q[3];
  assign core_reset = state != RUN;
  assign load_done  = state == RUN;
  assign load_error = err;

endmodule

// File: tb/tb_phoenix_rom_loader.sv
// Directed/randomised bench for phoenix_rom_loader against a byte-level model.
module tb_phoenix_rom_loader;

  localparam int PROG  = 16384;
  localparam int BG    = 4096;
  localparam int FG    = 4096;
  localparam int PROM  = 512;
  localparam int HOLD  = 64;
  localparam int TOTAL = PROG + BG + FG + PROM;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic        prog_we, bg_we, fg_we, prom_we;
  logic        core_reset, load_done, load_error;

  int checks = 0;
  int errors = 0;
  int cnt_we[4];
  int exp_max;
  bit exp_err;
  logic [15:0] exp_sum;

  always #5 clk_sys = ~clk_sys;

  phoenix_rom_loader dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .prog_we(prog_we),
    .bg_we(bg_we),
    .fg_we(fg_we),
    .prom_we(prom_we),
    .core_reset(core_reset),
    .load_done(load_done),
    .load_error(load_error)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {1'b0, prom_we, fg_we, bg_we, prog_we};
  endfunction

  // Region lookup straight from the memory map.
  task automatic model(input int a,
                       output logic [3:0] we,
                       output int off);
    we  = 4'b0000;
    off = 0;
    if (a < PROG) begin
      we = 4'b0001; off = a;
    end else if (a < PROG + BG) begin
      we = 4'b0010; off = a - PROG;
    end else if (a < PROG + BG + FG) begin
      we = 4'b0100; off = a - PROG - BG;
    end else if (a < TOTAL) begin
      we = 4'b1000; off = a - PROG - BG - FG;
    end
  endtask

  task automatic begin_dl();
    ioctl_download = 1'b1;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    exp_max = 0;
    exp_err = 1'b0;
    exp_sum = 16'h0000;
    for (int r = 0; r < 4; r++) cnt_we[r] = 0;
    tick();
  endtask

  task automatic send(input int a, input bit last);
    logic [7:0] d;
    logic [3:0] ew;
    int off;
    logic [3:0] ow;
    d = 8'($urandom);
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'(a);
    ioctl_dout     = d;
    ioctl_download = ~last;
    tick();
    model(a, ew, off);
    ow = {prom_we, fg_we, bg_we, prog_we};
    if (ew != 4'b0000) begin
      chk($sformatf("byte@%0d", a),
          {ow, rom_addr, rom_data},
          {ew, 14'(off), d});
      exp_sum = exp_sum + {8'h00, d};
    end else begin
      chk($sformatf("ovf@%0d", a), {60'd0, ow}, 64'd0);
      exp_err = 1'b1;
    end
    for (int r = 0; r < 4; r++)
      if (ow[r]) cnt_we[r]++;
    if (a == PROG)
      chk("bg_base", {bg_we, rom_addr}, {1'b1, 14'd0});
    if (a + 1 > exp_max) exp_max = a + 1;
    ioctl_wr = 1'b0;
  endtask

  task automatic finish_hold(input string tag);
    if (exp_max < TOTAL) exp_err = 1'b1;
`ifdef PHOENIX_ROM_CKSUM_EN
    if (exp_sum != 16'h0000) exp_err = 1'b1;
`endif
    repeat (HOLD - 1) tick();
    chk({tag, "_hold"}, {strobes(), core_reset, load_done},
        {5'b0, 1'b1, 1'b0});
    tick();
    chk({tag, "_run"}, {core_reset, load_done, load_error},
        {1'b0, 1'b1, exp_err});
  endtask

  task automatic full_load(input string tag);
    begin_dl();
    for (int i = 0; i < TOTAL; i++) send(i, i == TOTAL - 1);
    finish_hold(tag);
    chk({tag, "_prog"}, cnt_we[0], PROG);
    chk({tag, "_bg"},   cnt_we[1], BG);
    chk({tag, "_fg"},   cnt_we[2], FG);
    chk({tag, "_prom"}, cnt_we[3], PROM);
  endtask

  initial begin
    int sparse[9];
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) tick();
    chk("reset",
        {strobes(), rom_addr, rom_data,
         core_reset, load_done, load_error},
        {5'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0});
    reset_n = 1'b1;
    repeat (2) tick();
    chk("idle", {core_reset, load_done}, {1'b1, 1'b0});

    full_load("full");

    ioctl_download = 1'b1;
    ioctl_index    = 8'h01;
    for (int i = 0; i < 8; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'($urandom_range(0, TOTAL - 1));
      ioctl_dout = 8'($urandom);
      tick();
      chk("idx1", {strobes(), core_reset, load_done},
          {5'b0, 1'b0, 1'b1});
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();

    begin_dl();
    chk("reload", {core_reset, load_done, load_error},
        {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 20000; i++) send(i, i == 19999);
    finish_hold("short");

    sparse = '{0, 16383, 16384, 20479, 20480,
               24575, 24576, 25087, 25088};
    begin_dl();
    for (int i = 0; i < 9; i++) send(sparse[i], i == 8);
    chk("ovf_err", {63'd0, load_error}, 64'd1);
    finish_hold("ovf");

    begin_dl();
    for (int i = 0; i < 1000; i++) send(i, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd1000;
    reset_n    = 1'b0;
    #1;
    chk("rst_async",
        {strobes(), rom_addr, rom_data,
         core_reset, load_done, load_error},
        {5'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0});
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ioctl_addr = 25'(1001 + i);
      ioctl_dout = 8'($urandom);
      tick();
      chk("post_rst", {strobes(), core_reset, load_done},
          {5'b0, 1'b1, 1'b0});
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();
    full_load("again");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/phoenix_rom_loader.md
# phoenix_rom_loader

Download controller between the HPS ROM stream and the Phoenix core's ROM/PROM arrays. Decodes each streamed byte into one of four regions (program ROM, background tiles, foreground tiles, colour PROMs) and issues registered write strobes. Holds the core in reset during and after a download, then releases it and reports completion and status. Sits in the top-level `emu`, driven by `hps_io` ioctl signals, feeding the `phoenix` reset input and the ROM write ports.

## Interface
Parameters:
- PROG_SIZE, 16384, program ROM bytes; region 0 = [0, PROG_SIZE)
- BG_SIZE, 4096, background tile ROM bytes; follows program
- FG_SIZE, 4096, foreground tile ROM bytes; follows BG
- PROM_SIZE, 512, colour PROM bytes; follows FG
- HOLD_CYCLES, 64, clk_sys cycles core reset stays high after download ends (≥1)
- EXPECTED_SUM, 16'h0000, checksum reference (used only with checksum macro)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download window active
- ioctl_index  in  8  stream index; only 8'h00 is accepted
- ioctl_wr  in  1  byte valid, single-cycle
- ioctl_addr  in  25  byte address in stream
- ioctl_dout  in  8  byte data
- rom_addr  out  14  region-relative write address
- rom_data  out  8  write data
- prog_we / bg_we / fg_we / prom_we  out  1 each  one-hot write strobes
- core_reset  out  1  reset request to core (ORed with other resets at top)
- load_done  out  1  high once a complete download has finished
- load_error  out  1  short image, overflow byte, or checksum mismatch

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- IDLE (reset state): core_reset=1, load_done=0. ioctl_download=1 with index 0 → LOAD; byte counter and error cleared.
- LOAD: core_reset=1. Each accepted ioctl_wr registers addr/data; region select by addr compare against cumulative sizes; rom_addr = addr − region base, truncated to 14 bits. addr ≥ TOTAL (sum of sizes) → no strobe, load_error set. Byte counter tracks max(addr)+1. Falling ioctl_download → HOLD; if counter < TOTAL, load_error set.
- HOLD: core_reset=1; counter counts HOLD_CYCLES then → RUN.
- RUN: core_reset=0, load_done=1. New download (index 0) → LOAD, load_done cleared, core_reset=1 same cycle as transition.
- Downloads with index ≠ 0 ignored in every state; no strobes, no state change.
- ioctl_wr while ioctl_download=0 ignored.

## Timing
- Reset values: all strobes 0, rom_addr 0, rom_data 0, core_reset 1, load_done 0, load_error 0, state IDLE.
- Write latency: strobe, rom_addr, rom_data valid exactly 1 cycle after ioctl_wr; strobe width 1 cycle; back-to-back bytes every cycle supported, no backpressure.
- At most one strobe high per cycle.
- Last byte's strobe issued even if ioctl_download falls in the same cycle as its ioctl_wr.
- core_reset deasserts exactly HOLD_CYCLES cycles after the cycle ioctl_download is sampled low.
- reset_n low mid-download: immediate return to IDLE, strobes forced 0; subsequent bytes of that stream are ignored until a new rising ioctl_download.

## Configuration
- PHOENIX_ROM_CKSUM_EN defined: 16-bit wrapping sum of all in-range accepted bytes; on LOAD→HOLD, sum ≠ EXPECTED_SUM sets load_error. Sum cleared on entry to LOAD.
- Undefined: no adder, EXPECTED_SUM ignored; load_error from size/overflow only.

## Test plan
- Full image 25088 bytes, index 0, one per cycle → 16384 prog_we, 4096 bg_we, 4096 fg_we, 512 prom_we; byte at addr 16384 gives bg_we with rom_addr 0; load_done=1, core_reset low HOLD_CYCLES after download falls, load_error=0.
- Short image 20000 bytes → load_error=1, load_done=1 after hold.
- Byte at addr 25088 → no strobe, load_error=1; preceding bytes written normally.
- Index 8'h01 download in RUN → no strobes, core_reset stays 0, load_done stays 1.
- reset_n pulsed low at byte 1000 → strobes stop next edge, core_reset=1, state IDLE; new full download completes cleanly.
- With PHOENIX_ROM_CKSUM_EN, all bytes 8'h01, EXPECTED_SUM=16'h6200 → load_error=0; EXPECTED_SUM=16'h6201 → load_error=1.
